// File: rtl/lap_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lap_mem_ctrl
// Lap memory controller for a stopwatch. Holds up to eight BCD hh:mm:ss lap
// snapshots in a small circular buffer, lets the user step through them in
// recall mode, and wipes the whole buffer on a clear press.
//
// Build option: define LAP_OVERWRITE_EN to let a store into a full buffer
// replace the oldest entry. Without it, that store is rejected and err
// pulses for one cycle.
//
// Ports
//   clk         system clock, everything updates on its rising edge
//   rst         asynchronous active-high reset (memory contents are kept)
//   en          stopwatch mode enable, gates store/recall (not clear)
//   time_in     current stopwatch value, BCD hh:mm:ss (24 bits)
//   store_btn   debounced store button level
//   recall_btn  debounced recall button level
//   clr_btn     debounced clear button level
//   rd_mode     0 = store mode, 1 = recall mode
//   lap_out     last recalled lap value
//   lap_idx     logical index (0 = oldest) of lap_out
//   lap_valid   lap_out holds a recalled entry
//   cnt         number of stored entries, 0..8
//   full        cnt == 8
//   busy        FSM is not idle
//   err         one-cycle pulse when a store is rejected
// ---------------------------------------------------------------------------
module lap_mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] time_in,
    input  logic        store_btn,
    input  logic        recall_btn,
    input  logic        clr_btn,
    input  logic        rd_mode,
    output logic [23:0] lap_out,
    output logic [2:0]  lap_idx,
    output logic        lap_valid,
    output logic [3:0]  cnt,
    output logic        full,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_STORE, OP_RECALL, OP_CLEAR} op_t;

    state_t      r_state;
    state_t      w_nextState;
    op_t         r_pendOp;
    op_t         w_acceptOp;

    logic        r_storePrev;
    logic        r_recallPrev;
    logic        r_clrPrev;
    logic        r_rdModePrev;

    logic [23:0] r_mem [0:7];
    logic [23:0] r_snap;
    logic [2:0]  r_wrPtr;
    logic [2:0]  r_rdPtr;
    logic [2:0]  r_clrAddr;
    logic [3:0]  r_cnt;
    logic [23:0] r_lapOut;
    logic [2:0]  r_lapIdx;
    logic        r_lapValid;
    logic        r_err;

    logic        w_storeRise;
    logic        w_recallRise;
    logic        w_clrRise;
    logic        w_rdModeFall;
    logic        w_full;
    logic        w_canAccept;
    logic [2:0]  w_rdAddr;
    logic        w_memWe;
    logic [2:0]  w_memAddr;
    logic [23:0] w_memData;

    assign w_storeRise  = store_btn  & ~r_storePrev;
    assign w_recallRise = recall_btn & ~r_recallPrev;
    assign w_clrRise    = clr_btn    & ~r_clrPrev;
    assign w_rdModeFall = ~rd_mode   &  r_rdModePrev;

    assign w_full = (r_cnt == 4'd8);

    // Once the buffer has wrapped, the oldest entry sits at wr_ptr, so logical
    // index 0 is rebased there; before that the oldest entry is address 0.
    assign w_rdAddr = (w_full ? r_wrPtr : 3'd0) + r_rdPtr;

    // A press is only taken when nothing is pending or running, so presses
    // that arrive while an operation is in flight simply vanish.
    assign w_canAccept = (r_state == IDLE) && (r_pendOp == OP_NONE);

    // Decide which press (if any) to take this cycle: clear beats store
    // beats recall, and store/recall also need the right mode and enable.
    always_comb begin
        w_acceptOp = OP_NONE;
        if (w_canAccept) begin
            if (w_clrRise) begin
                w_acceptOp = OP_CLEAR;
            end else if (w_storeRise && en && !rd_mode) begin
                w_acceptOp = OP_STORE;
            end else if (w_recallRise && en && rd_mode) begin
                w_acceptOp = OP_RECALL;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: the accepted request waits one cycle in r_pendOp,
    // then the action state runs; CLEAR stays until address 7 is written.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                case (r_pendOp)
                    OP_STORE:  w_nextState = WRITE;
                    OP_RECALL: w_nextState = READ;
                    OP_CLEAR:  w_nextState = CLEAR;
                    default:   w_nextState = IDLE;
                endcase
            end
            WRITE:   w_nextState = IDLE;
            READ:    w_nextState = IDLE;
            CLEAR:   w_nextState = (r_clrAddr == 3'd7) ? IDLE : CLEAR;
            default: w_nextState = IDLE;
        endcase
    end

    // Memory write port: a lap snapshot in WRITE, zeros while clearing.
    always_comb begin
        w_memWe   = 1'b0;
        w_memAddr = r_wrPtr;
        w_memData = r_snap;
        case (r_state)
            WRITE: begin
`ifdef LAP_OVERWRITE_EN
                w_memWe = 1'b1;
`else
                w_memWe = !w_full;
`endif
            end
            CLEAR: begin
                w_memWe   = 1'b1;
                w_memAddr = r_clrAddr;
                w_memData = 24'd0;
            end
            default: w_memWe = 1'b0;
        endcase
    end

    // Lap storage has no reset so that reset leaves old contents in place;
    // writes are blocked while rst is high.
    always_ff @(posedge clk) begin
        if (w_memWe && !rst) begin
            r_mem[w_memAddr] <= w_memData;
        end
    end

    // Pointers, counters, recall outputs, edge detectors and err pulse.
    // A falling rd_mode is handled last so it wins over any READ update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pendOp     <= OP_NONE;
            r_storePrev  <= 1'b0;
            r_recallPrev <= 1'b0;
            r_clrPrev    <= 1'b0;
            r_rdModePrev <= 1'b0;
            r_snap       <= 24'd0;
            r_wrPtr      <= 3'd0;
            r_rdPtr      <= 3'd0;
            r_clrAddr    <= 3'd0;
            r_cnt        <= 4'd0;
            r_lapOut     <= 24'd0;
            r_lapIdx     <= 3'd0;
            r_lapValid   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_storePrev  <= store_btn;
            r_recallPrev <= recall_btn;
            r_clrPrev    <= clr_btn;
            r_rdModePrev <= rd_mode;
            r_pendOp     <= w_acceptOp;
            r_err        <= 1'b0;

            if (w_acceptOp == OP_STORE) begin
                r_snap <= time_in;
            end

            case (r_state)
                WRITE: begin
                    if (!w_full) begin
                        r_wrPtr <= r_wrPtr + 3'd1;
                        r_cnt   <= r_cnt + 4'd1;
                    end else begin
`ifdef LAP_OVERWRITE_EN
                        r_wrPtr <= r_wrPtr + 3'd1;
`else
                        r_err   <= 1'b1;
`endif
                    end
                end
                READ: begin
                    if (r_cnt != 4'd0) begin
                        r_lapOut   <= r_mem[w_rdAddr];
                        r_lapIdx   <= r_rdPtr;
                        r_lapValid <= 1'b1;
                        if (({1'b0, r_rdPtr} + 4'd1) == r_cnt) begin
                            r_rdPtr <= 3'd0;
                        end else begin
                            r_rdPtr <= r_rdPtr + 3'd1;
                        end
                    end
                end
                CLEAR: begin
                    r_clrAddr <= r_clrAddr + 3'd1;
                    if (r_clrAddr == 3'd7) begin
                        r_cnt      <= 4'd0;
                        r_wrPtr    <= 3'd0;
                        r_rdPtr    <= 3'd0;
                        r_lapOut   <= 24'd0;
                        r_lapIdx   <= 3'd0;
                        r_lapValid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase

            if (w_rdModeFall) begin
                r_rdPtr    <= 3'd0;
                r_lapValid <= 1'b0;
            end
        end
    end

    assign lap_out   = r_lapOut;
    assign lap_idx   = r_lapIdx;
    assign lap_valid = r_lapValid;
    assign cnt       = r_cnt;
    assign full      = w_full;
    assign busy      = (r_state != IDLE);
    assign err       = r_err;

endmodule

// File: doc/lap_mem_ctrl.md
LAP_MEM_CTRL -- requirements
Module: lap_mem_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port en, input, 1 bit: stopwatch mode enable; low = store/recall requests ignored.
REQ-004 SHALL have port time_in, input, 24 bits: current stopwatch value, BCD hh:mm:ss.
REQ-005 SHALL have ports store_btn, recall_btn and clr_btn, inputs, 1 bit each: synchronized, debounced button levels, high while pressed.
REQ-006 SHALL have port rd_mode, input, 1 bit: 0 = store mode, 1 = recall mode.
REQ-007 SHALL have port lap_out, output, 24 bits: last recalled lap value.
REQ-008 SHALL have port lap_idx, output, 3 bits: logical index (0 = oldest) of lap_out.
REQ-009 SHALL have port lap_valid, output, 1 bit: lap_out holds a recalled entry.
REQ-010 SHALL have ports cnt (output, 4 bits: stored entries 0..8) and full (output, 1 bit: cnt==8).
REQ-011 SHALL have port busy, output, 1 bit: FSM is not in IDLE.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse on a rejected store.

Function
REQ-013 SHALL hold an 8x24 lap memory, a write pointer wr_ptr[2:0] and a read pointer rd_ptr[2:0].
REQ-014 SHALL detect presses as rising edges of each button (registered previous level); one action per press.
REQ-015 SHALL use FSM states IDLE, WRITE, READ and CLEAR; busy=1 in every state except IDLE.
REQ-016 SHALL accept a press only in IDLE; presses detected while busy are discarded, not queued.
REQ-017 SHALL resolve simultaneous presses with priority clr > store > recall.
REQ-018 SHALL accept clr_btn regardless of en.
REQ-019 SHALL accept store only with en=1 and rd_mode=0, and recall only with en=1 and rd_mode=1; otherwise the press is ignored.
REQ-020 SHALL, for a press detected at edge k, capture time_in at edge k, enter the action state at edge k+1, update memory/outputs at edge k+2 and return to IDLE at edge k+2.
REQ-021 WRITE SHALL store the snapshot at mem[wr_ptr], advance wr_ptr modulo 8 and increment cnt, saturating at 8.
REQ-022 READ with cnt=0 SHALL leave lap_valid=0 and all outputs unchanged.
REQ-023 READ with cnt>0 SHALL set lap_out to the entry at logical index rd_ptr, lap_idx to rd_ptr and lap_valid to 1.
REQ-024 READ SHALL wrap rd_ptr to 0 when rd_ptr+1 equals cnt, and otherwise increment it.
REQ-025 SHALL map logical index i to physical address (base+i) mod 8, where base = wr_ptr when full=1 and 0 otherwise.
REQ-026 SHALL, on a falling edge of rd_mode, clear rd_ptr to 0 and lap_valid to 0 in the next cycle, whatever the FSM state.
REQ-027 CLEAR SHALL write zero to addresses 0..7, one per cycle (8 cycles).
REQ-028 CLEAR SHALL then set cnt, wr_ptr, rd_ptr, lap_out, lap_idx and lap_valid to 0 and return to IDLE.
REQ-029 CLEAR SHALL complete even if en drops during it.

Reset
REQ-030 rst=1 SHALL immediately force IDLE and set cnt, wr_ptr, rd_ptr, lap_out, lap_idx, lap_valid, busy, err and the edge-detect registers to 0.
REQ-031 rst SHALL NOT clear memory contents; entries are unreachable until rewritten because cnt=0.
REQ-032 rst asserted mid-WRITE or mid-CLEAR SHALL abort the operation with no further memory writes.

Configuration
REQ-033 Macro LAP_OVERWRITE_EN SHALL govern behaviour when a store is accepted with full=1.
REQ-034 With LAP_OVERWRITE_EN defined, that store SHALL overwrite the oldest entry, advance wr_ptr, keep cnt=8 and leave err=0.
REQ-035 With LAP_OVERWRITE_EN undefined, that store SHALL leave memory and pointers unchanged and pulse err for one cycle at edge k+2.

Verification
REQ-036 Store three presses with time_in=0x000105, 0x000210, 0x000330, then recall four presses -> lap_out 0x000105/0x000210/0x000330/0x000105, lap_idx 0,1,2,0, cnt=3.
REQ-037 Store nine presses, values 1..9 -> without macro: err pulses on the 9th, recall from 0 yields 1; with macro: no err, recall from 0 yields 2, cnt=8.
REQ-038 clr_btn and store_btn rise in the same cycle -> CLEAR runs for 8 cycles with busy=1, then cnt=0; the store is lost.
REQ-039 Recall press with cnt=0 -> lap_valid stays 0; store press during CLEAR -> ignored, cnt stays 0 afterwards.
REQ-040 Recall twice, drop rd_mode, raise it again and recall once -> lap_valid=0 after the drop, then lap_idx=0.
REQ-041 rst pulse in the second cycle of CLEAR -> all outputs 0 asynchronously, busy=0, no further writes.
